// File: rtl/child_arb_pkg.sv
// rtl/child_arb_pkg.sv - shared types and sizes for the child round-robin arbiter
package child_arb_pkg;

  localparam int ID_W    = 4;
  localparam int CHILD_N = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting at ptr
// Lower copy holds only candidates at or above ptr, so the lowest set bit of {elig, masked} is the cyclic winner.
module rr_pick
  import child_arb_pkg::*;
#(
  parameter int N = CHILD_N
) (
  input  logic [N-1:0]    elig,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [ID_W-1:0] idx,
  output logic            found
);

  logic [N-1:0]   hi_mask;
  logic [2*N-1:0] dbl;

  always_comb begin
    automatic int pos = 0;
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (i >= int'(ptr));
    end
    dbl   = {elig, elig & hi_mask};
    found = 1'b0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        found = 1'b1;
        pos   = i;
      end
    end
    if (pos >= N) begin
      pos = pos - N;
    end
    idx    = ID_W'(pos);
    onehot = '0;
    if (found) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/child_rr_arbiter.sv
// rtl/child_rr_arbiter.sv - round-robin grant of one shared port among sibling children
// Grants are held while requested, capped by MAX_HOLD; timed-out requesters stay masked until they drop.
module child_rr_arbiter
  import child_arb_pkg::*;
#(
  parameter int N_REQ    = CHILD_N,
  parameter int MAX_HOLD = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arb_en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic             timeout_pulse,
  output logic             err_sticky,
  output logic [ID_W-1:0]  err_id,
  input  logic             clr_err
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [HW-1:0] HOLD_SAT  = '1;

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic             timeout_pulse_q, timeout_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic [ID_W-1:0]  err_id_q, err_id_d;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_found;
  logic             rel_now;
  logic             forced;

  assign elig = req & ~mask_q;

  rr_pick #(.N(N_REQ)) u_pick (
    .elig   (elig),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    gnt_id_d        = gnt_id_q;
    ptr_d           = ptr_q;
    hold_cnt_d      = hold_cnt_q;
    mask_d          = mask_q & req;
    timeout_pulse_d = 1'b0;
    err_sticky_d    = err_sticky_q;
    err_id_d        = err_id_q;
    rel_now         = 1'b0;
    forced          = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_en && pick_found) begin
          state_d    = GRANT;
          gnt_d      = pick_onehot;
          gnt_id_d   = pick_idx;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
        if (!req[gnt_id_q]) begin
          rel_now = 1'b1;
        end else if (MAX_HOLD != 0 && hold_cnt_q == HOLD_LAST) begin
          rel_now = 1'b1;
          forced  = 1'b1;
        end
        if (rel_now) begin
          state_d = GAP;
          gnt_d   = '0;
          ptr_d   = (gnt_id_q == ID_W'(N_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);
        end
        if (forced) begin
          timeout_pulse_d  = 1'b1;
          mask_d[gnt_id_q] = 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A timeout in the same cycle as clr_err wins and records the new id
    if (clr_err) begin
      err_sticky_d = 1'b0;
      err_id_d     = '0;
    end
    if (forced) begin
      err_sticky_d = 1'b1;
      if (!err_sticky_q || clr_err) begin
        err_id_d = gnt_id_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      gnt_q           <= '0;
      gnt_id_q        <= '0;
      ptr_q           <= '0;
      hold_cnt_q      <= '0;
      mask_q          <= '0;
      timeout_pulse_q <= 1'b0;
      err_sticky_q    <= 1'b0;
      err_id_q        <= '0;
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      gnt_id_q        <= gnt_id_d;
      ptr_q           <= ptr_d;
      hold_cnt_q      <= hold_cnt_d;
      mask_q          <= mask_d;
      timeout_pulse_q <= timeout_pulse_d;
      err_sticky_q    <= err_sticky_d;
      err_id_q        <= err_id_d;
    end
  end

  assign gnt           = gnt_q;
  assign gnt_valid     = |gnt_q;
  assign gnt_id        = gnt_id_q;
  assign timeout_pulse = timeout_pulse_q;
  assign err_sticky    = err_sticky_q;
  assign err_id        = err_id_q;

endmodule

// File: tb/tb_child_rr_arbiter.sv
// tb/tb_child_rr_arbiter.sv - randomized and directed bench against a behavioural arbiter model
module tb_child_rr_arbiter;
  import child_arb_pkg::*;

  localparam int N  = CHILD_N;
  localparam int MH = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            arb_en;
  logic            clr_err;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [ID_W-1:0] gnt_id;
  logic            timeout_pulse;
  logic            err_sticky;
  logic [ID_W-1:0] err_id;

  always #5 clk = ~clk;

  child_rr_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .arb_en        (arb_en),
    .req           (req),
    .gnt           (gnt),
    .gnt_valid     (gnt_valid),
    .gnt_id        (gnt_id),
    .timeout_pulse (timeout_pulse),
    .err_sticky    (err_sticky),
    .err_id        (err_id),
    .clr_err       (clr_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: who owns the port, how long, cooling cycles, rotation start, masked children, status
  int owner, last_id, next_ptr, cool, held, stat_id;
  bit blocked[N];
  bit pulse, sticky;
  int order[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; last_id = 0; next_ptr = 0; cool = 0; held = 0;
    stat_id = 0; pulse = 0; sticky = 0;
    for (int i = 0; i < N; i++) blocked[i] = 0;
  endtask

  task automatic model_step();
    bit timed_out;
    int who;
    pulse = 0;
    timed_out = 0;
    if (clr_err) begin
      sticky = 0;
      stat_id = 0;
    end
    if (owner >= 0) begin
      held++;
      who = owner;
      timed_out = req[who] && (held == MH);
      if (!req[who] || timed_out) begin
        next_ptr = (who + 1) % N;
        owner = -1;
        cool = 1;
      end
      if (timed_out) begin
        pulse = 1;
        blocked[who] = 1;
        if (!sticky) stat_id = who;
        sticky = 1;
      end
    end else if (cool > 0) begin
      cool--;
    end else if (arb_en) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (next_ptr + k) % N;
        if (req[c] && !blocked[c]) begin
          owner = c; last_id = c; held = 0;
          order.push_back(c);
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) if (!req[i] && !(timed_out && i == who)) blocked[i] = 0;
  endtask

  task automatic tick();
    int exp_gnt;
    @(posedge clk);
    model_step();
    #1;
    exp_gnt = (owner >= 0) ? (1 << owner) : 0;
    check_eq("gnt", 32'(gnt), exp_gnt);
    check_eq("gnt_valid", 32'(gnt_valid), 32'(owner >= 0));
    check_eq("gnt_id", 32'(gnt_id), last_id);
    check_eq("timeout_pulse", 32'(timeout_pulse), 32'(pulse));
    check_eq("err_sticky", 32'(err_sticky), 32'(sticky));
    check_eq("err_id", 32'(err_id), stat_id);
  endtask

  task automatic wait_gnt(input int id, input int budget);
    int k = 0;
    while (!(gnt_valid && gnt_id == ID_W'(id)) && k < budget) begin
      tick();
      k++;
    end
    check_eq("wait_gnt", 32'(gnt), 32'(1 << id));
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int hi_cnt, p_cnt, k;
    rst_n = 0; arb_en = 1; clr_err = 0; req = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_gnt", 32'(gnt), 0);
    check_eq("rst_valid", 32'(gnt_valid), 0);
    check_eq("rst_gnt_id", 32'(gnt_id), 0);
    check_eq("rst_pulse", 32'(timeout_pulse), 0);
    check_eq("rst_sticky", 32'(err_sticky), 0);
    check_eq("rst_err_id", 32'(err_id), 0);
    req = '0;
    rst_n = 1;
    idle_ticks(10);

    // Fairness: everyone requests, each drops for one cycle after two granted cycles
    order.delete();
    req = '1;
    k = 0;
    while (order.size() < 16 && k < 200) begin
      tick();
      req = '1;
      if (owner >= 0 && held == 1) req[owner] = 1'b0;
      k++;
    end
    check_eq("fair_count", order.size(), 16);
    for (int i = 0; i < 16 && i < order.size(); i++) check_eq("fair_order", order[i], i % N);
    req = '0;
    idle_ticks(4);

    // Single requester on child 3 for five cycles
    req = 15'h0008;
    hi_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (gnt == 15'h0008) hi_cnt++;
    end
    req = '0;
    tick();
    if (gnt == 15'h0008) hi_cnt++;
    check_eq("single_cycles", hi_cnt, 5);
    idle_ticks(4);

    // Wrap: grant 14, then 0 and 14 compete
    req = 15'h4000;
    wait_gnt(14, 20);
    req = '0;
    tick();
    order.delete();
    req = 15'h4001;
    idle_ticks(4);
    check_eq("wrap_count", order.size(), 1);
    if (order.size() > 0) check_eq("wrap_id", order[0], 0);
    req = '0;
    idle_ticks(4);

    // Timeout on child 5, then regrant only after a one-cycle drop
    req = 15'h0020;
    hi_cnt = 0; p_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt[5]) hi_cnt++;
      if (timeout_pulse) p_cnt++;
    end
    check_eq("to_hold_cycles", hi_cnt, MH);
    check_eq("to_pulses", p_cnt, 1);
    check_eq("to_sticky", 32'(err_sticky), 1);
    check_eq("to_err_id", 32'(err_id), 5);
    req = '0;
    tick();
    req = 15'h0020;
    wait_gnt(5, 6);
    req = '0;
    idle_ticks(3);

    // Timeout on child 7 together with clr_err: the new id is recorded
    req = 15'h0080;
    k = 0;
    while (!(owner == 7 && held == MH - 1) && k < 30) begin
      tick();
      k++;
    end
    clr_err = 1;
    tick();
    clr_err = 0;
    check_eq("clr_vs_to_sticky", 32'(err_sticky), 1);
    check_eq("clr_vs_to_id", 32'(err_id), 7);
    req = '0;
    tick();
    clr_err = 1;
    tick();
    clr_err = 0;
    check_eq("clr_sticky", 32'(err_sticky), 0);
    check_eq("clr_err_id", 32'(err_id), 0);
    idle_ticks(3);

    // arb_en drop mid-grant: current grant completes, nothing new issues
    req = 15'h0004;
    wait_gnt(2, 10);
    arb_en = 0;
    idle_ticks(2);
    req = 15'h7FFB;
    hi_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (gnt_valid && gnt_id != 2) hi_cnt++;
    end
    check_eq("en_low_new_grants", hi_cnt, 0);
    arb_en = 1;
    idle_ticks(5);
    req = '0;
    idle_ticks(12);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) req[$urandom_range(N - 1)] ^= 1'b1;
      arb_en  = ($urandom_range(15) != 0);
      clr_err = ($urandom_range(31) == 0);
      tick();
    end
    clr_err = 0;
    arb_en = 1;

    // Reset asserted in the middle of a grant
    req = 15'h0010;
    idle_ticks(6);
    wait_gnt(4, 20);
    tick();
    #3;
    rst_n = 0;
    #1;
    check_eq("midrst_gnt", 32'(gnt), 0);
    check_eq("midrst_pulse", 32'(timeout_pulse), 0);
    check_eq("midrst_gnt_id", 32'(gnt_id), 0);
    check_eq("midrst_sticky", 32'(err_sticky), 0);
    model_reset();
    @(posedge clk);
    #1;
    req = '0;
    rst_n = 1;
    idle_ticks(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/child_rr_arbiter.md
# child_rr_arbiter

Round-robin arbiter that shares one downstream resource port among the 15 sibling child instances of a level-28 subtree wrapper. It grants one child at a time, holds the grant while that child keeps requesting, and enforces a per-grant hold limit with a timeout. Timed-out requesters are masked, and errors are reported as sticky status. It sits inside the subtree wrapper, next to the `inst_0`..`inst_14` children.

## Interface
- `N_REQ`, default 15: number of requesters. Legal range 2..16.
- `MAX_HOLD`, default 64: maximum consecutive grant cycles. 0 disables the timeout.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: **one clock; reset is asynchronous and active-low.**
- `arb_en`, input, 1: when low, no new grants are issued; a grant already in progress runs to release.
- `req`, input, N_REQ: level request, one bit per child.
- `gnt`, output, N_REQ: one-hot grant, registered.
- `gnt_valid`, output, 1: equals |gnt.
- `gnt_id`, output, 4: index of the granted child. Holds its last value when `gnt_valid`=0.
- `timeout_pulse`, output, 1: one-cycle pulse on a forced release.
- `err_sticky`, output, 1: set on any timeout; cleared by `clr_err`.
- `err_id`, output, 4: `gnt_id` of the first timeout since the last clear.
- `clr_err`, input, 1: synchronous clear of `err_sticky` and `err_id`.

## Operation
- Reset values:
  - `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0.
  - `timeout_pulse` = 0, `err_sticky` = 0, `err_id` = 0.
  - Pointer `ptr` = 0, mask = 0, state IDLE.
- States are IDLE, GRANT and GAP.
- **IDLE**
  - The eligible set is `req & ~mask`.
  - If `arb_en` and the eligible set is non-empty, select the first eligible index at or above `ptr`, scanning cyclically (N_REQ-1 wraps to 0).
  - Register `gnt` and `gnt_id` for that index, clear the hold counter, and go to GRANT.
- **GRANT**
  - `hold_cnt` increments each cycle.
  - Normal release: when `req[gnt_id]` is sampled low, go to GAP.
  - Forced release: when `MAX_HOLD`≠0 and `hold_cnt` = MAX_HOLD-1 with `req[gnt_id]` still high:
    - go to GAP and pulse `timeout_pulse`;
    - set `mask[gnt_id]`;
    - set `err_sticky`; load `err_id` only if `err_sticky` was 0.
  - On either release, `ptr` ← `gnt_id`+1, wrapping to 0 after N_REQ-1.
- **GAP**
  - Lasts exactly 1 cycle with `gnt` = 0, then returns to IDLE.
- **Mask**
  - `mask[i]` clears in any cycle where `req[i]` = 0.
  - It never clears while `req[i]` is held high.
- **Simultaneous events**
  - `clr_err` in the same cycle as a new timeout: the set wins, and `err_id` loads the new id.
  - `arb_en` falling during GRANT has no effect on the current grant.
- `gnt` and `gnt_id` change only on the GRANT entry and exit edges.
- Requests asserted during GAP are evaluated in the following IDLE cycle.
- Reset asserted mid-grant: all outputs drop asynchronously to their reset values. No pulse is produced.

## Timing
- Grant latency: `req` seen in IDLE at edge t gives `gnt` high after edge t (visible in cycle t+1).
- Release latency: `req[gnt_id]` low at edge t gives `gnt` low in cycle t+1 (GAP) and IDLE in cycle t+2. The earliest next grant is visible in cycle t+3.
- Minimum `gnt`-low gap between grants: 2 cycles.
- Maximum `gnt` high time: MAX_HOLD cycles. `timeout_pulse` coincides with the first `gnt`-low cycle.
- `hold_cnt` width: $clog2(MAX_HOLD+1), saturating, never wraps.

## Structure
- Shared package `child_arb_pkg`:
  - state enum `arb_state_e` {IDLE, GRANT, GAP};
  - `ID_W` = 4;
  - `CHILD_N` = 15.
- One sub-module, `rr_pick`: purely combinational. It takes the eligible vector and `ptr` and returns the one-hot result, the index and a found flag, using a double-width mask-and-priority scheme.
- The FSM, counter, mask and error logic live in `child_rr_arbiter`.

## Test plan
- **Reset:** hold `rst_n` = 0 with `req` = 15'h7FFF → all outputs 0. Release reset, `req` = 0 → `gnt` stays 0 for 10 cycles.
- **Single requester:** `req[3]` pulsed high for 5 cycles → `gnt` = 15'h0008 in cycles t+1..t+5, `gnt_id` = 3, then `gnt` = 0 and `ptr` = 4.
- **Fairness:** all 15 `req` held high, `MAX_HOLD` = 0, each child drops its `req` after 2 granted cycles and reasserts → grant order 0,1,…,14,0. No child is granted twice before all others are served.
- **Wrap:** last grant was id 14, then `req` = {bit 0, bit 14} → grant id 0.
- **Timeout:** `MAX_HOLD` = 8, `req[5]` held high → `gnt[5]` high for exactly 8 cycles, `timeout_pulse` for 1 cycle, `err_sticky` = 1, `err_id` = 5. `req[5]` is not regranted until it drops for one cycle. Then `clr_err` → status clears.
- **Enable and mid-grant reset:** `arb_en` drops during a grant of id 2 → id 2 completes, and no new grant occurs while `arb_en` = 0. In a separate run, assert `rst_n` = 0 mid-grant → `gnt` = 0 immediately and `timeout_pulse` = 0.
